tmm2018_access_ctrl: RTL and testbench

- Synchronous sequencer and arbiter that shares one TMM2018D-25 2Kx8 static RAM between two requesters, e.g. a CPU port and a DMA port.
- Converts a req/ack handshake into CS_n/OE_n/W_n strobe sequences with address setup, programmable strobe width and hold.
- Sits between the requesters and the RAM; the RAM data pins are split into a drive bus, an enable and a sense bus.

---
 rtl/tmm2018_access_ctrl_if.sv | 39 +++
 rtl/tmm2018_access_ctrl.sv | 154 +++++++++++++++
 tb/tb_tmm2018_access_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tmm2018_access_ctrl_if.sv
// Signal bundle between the two requesters / SRAM pins and tmm2018_access_ctrl.
// master: the environment (requesters plus the RAM); slave: the controller.
interface tmm2018_access_ctrl_if #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 8
);
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              ack0;
    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              ack1;
    logic [DATA_W-1:0] rdata;
    logic              grant;
    logic              busy;
    logic [ADDR_W-1:0] sram_a;
    logic              sram_cs_n;
    logic              sram_oe_n;
    logic              sram_w_n;
    logic [DATA_W-1:0] sram_dq_o;
    logic              sram_dq_oe;
    logic [DATA_W-1:0] sram_dq_i;

    modport master (
        output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, sram_dq_i,
        input  ack0, ack1, rdata, grant, busy,
        input  sram_a, sram_cs_n, sram_oe_n, sram_w_n, sram_dq_o, sram_dq_oe
    );

    modport slave (
        input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, sram_dq_i,
        output ack0, ack1, rdata, grant, busy,
        output sram_a, sram_cs_n, sram_oe_n, sram_w_n, sram_dq_o, sram_dq_oe
    );
endinterface

// File: rtl/tmm2018_access_ctrl.sv
// Two-port round-robin sequencer for a shared TMM2018D-25 2Kx8 static RAM.
// Each granted access runs SETUP -> STROBE (N cycles) -> HOLD and then returns to IDLE;
// every output is a register so the RAM pins are glitch-free.
module tmm2018_access_ctrl #(
    parameter int unsigned ADDR_W        = 11,
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned STROBE_CYCLES = 2
) (
    input logic                 sysclk,
    input logic                 sys_rst_n,
    tmm2018_access_ctrl_if.slave bus
);
    // A zero strobe width would skip the strobe entirely, so it is stretched to one cycle.
    localparam int unsigned StrobeN = (STROBE_CYCLES == 0) ? 1 : STROBE_CYCLES;
    localparam int unsigned CntW    = (StrobeN > 1) ? $clog2(StrobeN) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(StrobeN - 1);

    typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StHold} stateE;

    stateE             stateQ, stateD;
    logic [CntW-1:0]   cntQ, cntD;
    logic              lastQ, lastD;
    logic              weQ, weD;
    logic              grantQ, grantD;
    logic              busyQ, busyD;
    logic [ADDR_W-1:0] aQ, aD;
    logic              csNQ, csND;
    logic              oeNQ, oeND;
    logic              wNQ, wND;
    logic [DATA_W-1:0] dqOQ, dqOD;
    logic              dqOeQ, dqOeD;
    logic              ack0Q, ack0D;
    logic              ack1Q, ack1D;
    logic [DATA_W-1:0] rdataQ, rdataD;
    logic              pick1;

    // Next state plus next value of every registered output; strobes default inactive.
    always_comb begin
        stateD = stateQ;
        cntD   = cntQ;
        lastD  = lastQ;
        weD    = weQ;
        grantD = grantQ;
        busyD  = busyQ;
        aD     = aQ;
        csND   = csNQ;
        oeND   = 1'b1;
        wND    = 1'b1;
        dqOD   = dqOQ;
        dqOeD  = dqOeQ;
        ack0D  = 1'b0;
        ack1D  = 1'b0;
        rdataD = rdataQ;
        // A lone request wins; on a tie the port that did not go last wins.
        pick1  = bus.req1 && (!bus.req0 || !lastQ);

        unique case (stateQ)
            StIdle: begin
                csND  = 1'b1;
                dqOeD = 1'b0;
                if (bus.req0 || bus.req1) begin
                    stateD = StSetup;
                    grantD = pick1;
                    lastD  = pick1;
                    weD    = pick1 ? bus.we1 : bus.we0;
                    aD     = pick1 ? bus.addr1 : bus.addr0;
                    csND   = 1'b0;
                    dqOeD  = weD;
                    if (weD) begin
                        dqOD = pick1 ? bus.wdata1 : bus.wdata0;
                    end
                end
            end
            StSetup: begin
                stateD = StStrobe;
                cntD   = CntLoad;
                oeND   = weQ;
                wND    = !weQ;
            end
            StStrobe: begin
                if (cntQ == '0) begin
                    stateD = StHold;
                    ack0D  = !grantQ;
                    ack1D  = grantQ;
                    // Capture on the edge that ends the last strobe cycle.
                    if (!weQ) begin
                        rdataD = bus.sram_dq_i;
                    end
                end else begin
                    cntD = cntQ - CntW'(1);
                    oeND = weQ;
                    wND  = !weQ;
                end
            end
            StHold: begin
                stateD = StIdle;
                csND   = 1'b1;
                dqOeD  = 1'b0;
            end
            default: stateD = StIdle;
        endcase

        busyD = (stateD != StIdle);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge sysclk) begin
        if (!sys_rst_n) begin
            stateQ <= StIdle;
            cntQ   <= '0;
            lastQ  <= 1'b1;
            weQ    <= 1'b0;
            grantQ <= 1'b0;
            busyQ  <= 1'b0;
            aQ     <= '0;
            csNQ   <= 1'b1;
            oeNQ   <= 1'b1;
            wNQ    <= 1'b1;
            dqOQ   <= '0;
            dqOeQ  <= 1'b0;
            ack0Q  <= 1'b0;
            ack1Q  <= 1'b0;
            rdataQ <= '0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
            lastQ  <= lastD;
            weQ    <= weD;
            grantQ <= grantD;
            busyQ  <= busyD;
            aQ     <= aD;
            csNQ   <= csND;
            oeNQ   <= oeND;
            wNQ    <= wND;
            dqOQ   <= dqOD;
            dqOeQ  <= dqOeD;
            ack0Q  <= ack0D;
            ack1Q  <= ack1D;
            rdataQ <= rdataD;
        end
    end

    assign bus.ack0       = ack0Q;
    assign bus.ack1       = ack1Q;
    assign bus.rdata      = rdataQ;
    assign bus.grant      = grantQ;
    assign bus.busy       = busyQ;
    assign bus.sram_a     = aQ;
    assign bus.sram_cs_n  = csNQ;
    assign bus.sram_oe_n  = oeNQ;
    assign bus.sram_w_n   = wNQ;
    assign bus.sram_dq_o  = dqOQ;
    assign bus.sram_dq_oe = dqOeQ;
endmodule

// File: tb/tb_tmm2018_access_ctrl.sv
// Bench for tmm2018_access_ctrl: a scoreboard of predicted transactions (port, data,
// pin window, ack cycle) checked by a negedge monitor, plus two short-strobe instances.
module tb_tmm2018_access_ctrl;
    localparam int unsigned AW = 11;
    localparam int unsigned DW = 8;
    localparam int NM = 2;

    typedef struct {
        bit         port;
        bit         wr;
        logic [10:0] addr;
        logic [7:0] data;
        int         s;
        int         ack;
    } txnT;

    logic sysclk = 1'b0;
    logic sys_rst_n = 1'b0;
    always #5 sysclk = ~sysclk;

    tmm2018_access_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    tmm2018_access_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) busA ();
    tmm2018_access_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) busB ();

    tmm2018_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .STROBE_CYCLES(NM)) dut (
        .sysclk(sysclk), .sys_rst_n(sys_rst_n), .bus(bus));
    tmm2018_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .STROBE_CYCLES(1)) dutA (
        .sysclk(sysclk), .sys_rst_n(sys_rst_n), .bus(busA));
    tmm2018_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .STROBE_CYCLES(0)) dutB (
        .sysclk(sysclk), .sys_rst_n(sys_rst_n), .bus(busB));

    int   checks = 0;
    int   fails = 0;
    int   cyc = 0;
    logic rstSeen = 1'b1;
    bit   skipPins = 1'b0;
    txnT  sbq[$];
    logic [7:0] expRdata = '0;
    bit   expGrant = 1'b0;

    // Reference model state
    logic [7:0] refMem [0:2047];
    int   freeCycle = 0;
    bit   lastModel = 1'b1;

    // SRAM pin model
    logic [7:0] simMem [0:2047];

    function automatic logic [7:0] initPat(input int a);
        if (a == 32'h3A5) return 8'hC7;
        return 8'(a * 7 + 3);
    endfunction

    always @(posedge sysclk) begin
        cyc <= cyc + 1;
        rstSeen <= sys_rst_n;
    end

    always @(posedge sysclk) begin
        if (cyc == 0) begin
            for (int i = 0; i < 2048; i++) simMem[i] <= initPat(i);
        end else if (!bus.sram_cs_n && !bus.sram_w_n && bus.sram_dq_oe) begin
            simMem[bus.sram_a] <= bus.sram_dq_o;
        end
    end

    assign bus.sram_dq_i  = (!bus.sram_cs_n && !bus.sram_oe_n) ? simMem[bus.sram_a] : 8'hEE;
    assign busA.sram_dq_i = (!busA.sram_oe_n) ? (busA.sram_a[7:0] ^ 8'h5C) : 8'hEE;
    assign busB.sram_dq_i = (!busB.sram_oe_n) ? (busB.sram_a[7:0] ^ 8'h5C) : 8'hEE;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic invCheck(input string tag, input logic oeN, input logic wN,
                            input logic csN, input logic dqOe);
        chk({tag, "_inv_oe_w"}, 32'(oeN | wN), 32'd1);
        chk({tag, "_inv_w_drive"}, 32'(wN | (dqOe & !csN)), 32'd1);
        chk({tag, "_inv_dq_oe"}, 32'(!(dqOe & !oeN)), 32'd1);
    endtask

    // Spec-level timing: a request seen idle in cycle s finishes with ack in s+N+2,
    // and the controller is free again in s+N+3.
    task automatic predict(input bit p, input bit w, input logic [10:0] a,
                           input logic [7:0] d, input int start);
        txnT t;
        int  s;
        s = (start > freeCycle) ? start : freeCycle;
        t.port = p;
        t.wr   = w;
        t.addr = a;
        t.s    = s;
        t.ack  = s + NM + 2;
        if (w) begin
            refMem[a] = d;
            t.data = d;
        end else begin
            t.data = refMem[a];
        end
        freeCycle = t.ack + 1;
        lastModel = p;
        sbq.push_back(t);
    endtask

    task automatic drive(input bit p, input bit r, input bit w, input logic [10:0] a,
                         input logic [7:0] d);
        if (!p) begin
            bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
        end else begin
            bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
        end
    endtask

    task automatic issue(input bit p, input bit w, input logic [10:0] a, input logic [7:0] d);
        drive(p, 1'b1, w, a, d);
        predict(p, w, a, d, cyc);
    endtask

    task automatic drop(input bit p);
        if (!p) bus.req0 = 1'b0;
        else bus.req1 = 1'b0;
    endtask

    task automatic waitAck(input bit p);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge sysclk);
            if (p ? bus.ack1 : bus.ack0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("ack_wait", 32'(ok), 32'd1);
    endtask

    task automatic smallTxn(input bit w, input logic [10:0] a, input logic [7:0] d);
        int c, ackA, ackB, oeA, oeB, wA, wB;
        logic [7:0] rdA, rdB, want;
        @(negedge sysclk);
        c = cyc;
        busA.req0 = 1'b1; busA.we0 = w; busA.addr0 = a; busA.wdata0 = d;
        busB.req0 = 1'b1; busB.we0 = w; busB.addr0 = a; busB.wdata0 = d;
        ackA = -1; ackB = -1; oeA = 0; oeB = 0; wA = 0; wB = 0; rdA = '0; rdB = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge sysclk);
            if (!busA.sram_oe_n) oeA++;
            if (!busB.sram_oe_n) oeB++;
            if (!busA.sram_w_n) wA++;
            if (!busB.sram_w_n) wB++;
            if (busA.ack0) begin ackA = cyc; rdA = busA.rdata; busA.req0 = 1'b0; end
            if (busB.ack0) begin ackB = cyc; rdB = busB.rdata; busB.req0 = 1'b0; end
        end
        want = a[7:0] ^ 8'h5C;
        chk("n1_ack_cycle", 32'(ackA), 32'(c + 3));
        chk("n0_ack_cycle", 32'(ackB), 32'(c + 3));
        chk("n1_oe_cycles", 32'(oeA), w ? 32'd0 : 32'd1);
        chk("n0_oe_cycles", 32'(oeB), w ? 32'd0 : 32'd1);
        chk("n1_w_cycles", 32'(wA), w ? 32'd1 : 32'd0);
        chk("n0_w_cycles", 32'(wB), w ? 32'd1 : 32'd0);
        if (!w) begin
            chk("n1_rdata", 32'(rdA), 32'(want));
            chk("n0_rdata", 32'(rdB), 32'(want));
        end
    endtask

    // Monitor: invariants, reset values, per-cycle pin window, acks and rdata.
    always @(negedge sysclk) begin : monitor
        txnT t;
        bit  inWin;
        bit  strobe;
        if (cyc > 0) begin
            invCheck("main", bus.sram_oe_n, bus.sram_w_n, bus.sram_cs_n, bus.sram_dq_oe);
            invCheck("n1", busA.sram_oe_n, busA.sram_w_n, busA.sram_cs_n, busA.sram_dq_oe);
            invCheck("n0", busB.sram_oe_n, busB.sram_w_n, busB.sram_cs_n, busB.sram_dq_oe);
            if (!rstSeen) begin
                expRdata = '0;
                expGrant = 1'b0;
                chk("rst_cs_n", 32'(bus.sram_cs_n), 32'd1);
                chk("rst_oe_n", 32'(bus.sram_oe_n), 32'd1);
                chk("rst_w_n", 32'(bus.sram_w_n), 32'd1);
                chk("rst_dq_oe", 32'(bus.sram_dq_oe), 32'd0);
                chk("rst_dq_o", 32'(bus.sram_dq_o), 32'd0);
                chk("rst_sram_a", 32'(bus.sram_a), 32'd0);
                chk("rst_acks", 32'({bus.ack1, bus.ack0}), 32'd0);
                chk("rst_busy", 32'(bus.busy), 32'd0);
                chk("rst_grant", 32'(bus.grant), 32'd0);
                chk("rst_rdata", 32'(bus.rdata), 32'd0);
            end else begin
                inWin = (sbq.size() > 0) && (cyc >= sbq[0].s + 1) && (cyc <= sbq[0].ack);
                if (!skipPins) begin
                    if (inWin) begin
                        t = sbq[0];
                        strobe = (cyc >= t.s + 2) && (cyc < t.ack);
                        expGrant = t.port;
                        chk("cs_n", 32'(bus.sram_cs_n), 32'd0);
                        chk("oe_n", 32'(bus.sram_oe_n), 32'(t.wr || !strobe));
                        chk("w_n", 32'(bus.sram_w_n), 32'(!t.wr || !strobe));
                        chk("dq_oe", 32'(bus.sram_dq_oe), 32'(t.wr));
                        chk("sram_a", 32'(bus.sram_a), 32'(t.addr));
                        if (t.wr) chk("dq_o", 32'(bus.sram_dq_o), 32'(t.data));
                        chk("busy", 32'(bus.busy), 32'd1);
                    end else begin
                        chk("idle_strobes",
                            32'({bus.sram_cs_n, bus.sram_oe_n, bus.sram_w_n}), 32'd7);
                        chk("idle_dq_oe", 32'(bus.sram_dq_oe), 32'd0);
                        chk("idle_busy", 32'(bus.busy), 32'd0);
                    end
                    chk("grant", 32'(bus.grant), 32'(expGrant));
                end
                chk("ack_both", 32'(bus.ack0 & bus.ack1), 32'd0);
                if (bus.ack0 || bus.ack1) begin
                    if (sbq.size() == 0) begin
                        chk("ack_unexpected", 32'({bus.ack1, bus.ack0}), 32'd0);
                    end else begin
                        t = sbq.pop_front();
                        chk("ack_port", 32'(bus.ack1), 32'(t.port));
                        chk("ack_cycle", 32'(cyc), 32'(t.ack));
                        if (!t.wr) expRdata = t.data;
                    end
                end else if (sbq.size() > 0 && cyc > sbq[0].ack) begin
                    chk("ack_missing", 32'(cyc), 32'(sbq[0].ack));
                    void'(sbq.pop_front());
                end
                chk("rdata", 32'(bus.rdata), 32'(expRdata));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d failures so far", fails);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        bit          p, w, curP, d0, d1, first;
        logic [10:0] a;
        logic [7:0]  d;
        int          n0, n1, gap, idx;
        bit          cw [2][3];
        logic [10:0] ca [2][3];
        logic [7:0]  cd [2][3];

        for (int i = 0; i < 2048; i++) refMem[i] = initPat(i);
        bus.req0 = 0; bus.we0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.wdata1 = '0;
        busA.req0 = 0; busA.we0 = 0; busA.addr0 = '0; busA.wdata0 = '0;
        busA.req1 = 0; busA.we1 = 0; busA.addr1 = '0; busA.wdata1 = '0;
        busB.req0 = 0; busB.we0 = 0; busB.addr0 = '0; busB.wdata0 = '0;
        busB.req1 = 0; busB.we1 = 0; busB.addr1 = '0; busB.wdata1 = '0;
        sys_rst_n = 1'b0;
        repeat (3) @(negedge sysclk);
        sys_rst_n = 1'b1;
        @(negedge sysclk);

        // Directed read of a preloaded word, then write + read-back.
        issue(1'b0, 1'b0, 11'h3A5, 8'h00);
        waitAck(1'b0); drop(1'b0);
        @(negedge sysclk);
        issue(1'b1, 1'b1, 11'h7FF, 8'h5A);
        waitAck(1'b1); drop(1'b1);
        @(negedge sysclk);
        issue(1'b0, 1'b0, 11'h7FF, 8'h00);
        waitAck(1'b0); drop(1'b0);

        // Back-to-back: req0 held through ack with a new address.
        @(negedge sysclk);
        issue(1'b0, 1'b0, 11'h123, 8'h00);
        waitAck(1'b0);
        issue(1'b0, 1'b0, 11'h045, 8'h00);
        waitAck(1'b0); drop(1'b0);

        // Contention: both ports held for three random transactions each.
        @(negedge sysclk);
        for (int j = 0; j < 3; j++) begin
            for (int q = 0; q < 2; q++) begin
                cw[q][j] = 1'($urandom_range(0, 1));
                ca[q][j] = 11'($urandom_range(0, 255));
                cd[q][j] = 8'($urandom);
            end
        end
        first = !lastModel;
        for (int k = 0; k < 6; k++) begin
            p = first ^ k[0];
            idx = k / 2;
            predict(p, cw[p][idx], ca[p][idx], cd[p][idx], cyc);
        end
        drive(1'b0, 1'b1, cw[0][0], ca[0][0], cd[0][0]);
        drive(1'b1, 1'b1, cw[1][0], ca[1][0], cd[1][0]);
        n0 = 1; n1 = 1; d0 = 0; d1 = 0;
        for (int i = 0; i < 80 && !(d0 && d1); i++) begin
            @(negedge sysclk);
            if (bus.ack0 && !d0) begin
                if (n0 < 3) begin drive(1'b0, 1'b1, cw[0][n0], ca[0][n0], cd[0][n0]); n0++; end
                else begin drop(1'b0); d0 = 1; end
            end
            if (bus.ack1 && !d1) begin
                if (n1 < 3) begin drive(1'b1, 1'b1, cw[1][n1], ca[1][n1], cd[1][n1]); n1++; end
                else begin drop(1'b1); d1 = 1; end
            end
        end
        chk("contention_done", 32'({d1, d0}), 32'd3);

        // Reset in the first STROBE cycle of a write: no ack, reset values next cycle.
        @(negedge sysclk);
        skipPins = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 11'h400, 8'h99);
        repeat (2) @(negedge sysclk);
        sys_rst_n = 1'b0;
        drop(1'b1);
        @(negedge sysclk);
        sys_rst_n = 1'b1;
        skipPins = 1'b0;
        lastModel = 1'b1;
        freeCycle = 0;
        @(negedge sysclk);
        issue(1'b0, 1'b1, 11'h0A0, 8'h3C);
        waitAck(1'b0); drop(1'b0);
        @(negedge sysclk);
        issue(1'b1, 1'b0, 11'h0A0, 8'h00);
        waitAck(1'b1); drop(1'b1);

        // Random single-port traffic with random gaps, including zero-gap reissue.
        @(negedge sysclk);
        curP = 1'($urandom_range(0, 1));
        issue(curP, 1'($urandom_range(0, 1)), 11'($urandom_range(0, 255)), 8'($urandom));
        for (int k = 0; k < 40; k++) begin
            waitAck(curP);
            drop(curP);
            p = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            a = 11'($urandom_range(0, 255));
            d = 8'($urandom);
            gap = $urandom_range(0, 2);
            repeat (gap) @(negedge sysclk);
            issue(p, w, a, d);
            curP = p;
        end
        waitAck(curP);
        drop(curP);

        // Short-strobe instances (N=1 and N=0 behave identically).
        smallTxn(1'b0, 11'h1B7, 8'h00);
        smallTxn(1'b1, 11'h022, 8'hA5);
        smallTxn(1'b0, 11'h7C3, 8'h00);

        repeat (4) @(negedge sysclk);
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
